// File: rtl/kbd_port_sequencer.sv
// PS/2 scan-code decoder feeding three PicoBlaze input ports (direction, digit FIFO, commit).
// Optional feature: define TYPEMATIC_FILTER_EN to suppress auto-repeat makes until the break.
module kbd_port_sequencer #(
  parameter logic [7:0]  ADDR_DIR    = 8'h05,
  parameter logic [7:0]  ADDR_DAT    = 8'h06,
  parameter logic [7:0]  ADDR_CMT    = 8'h07,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Valid,
  input  logic [7:0] Port_ID,
  input  logic       Read_Strobe,
  output logic [7:0] Keyboard_Output,
  output logic       Key_Pending,
  output logic       Overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBreak, StExtBreak} state_e;

  function automatic logic is_dir_code(input logic [7:0] c);
    logic r;
    case (c)
      8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
      8'h09, 8'h78, 8'h07, 8'h0D, 8'hF5, 8'hF2, 8'hEB, 8'hF4: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Returns {hit, value}.
  function automatic logic [4:0] digit_of(input logic [7:0] c);
    logic [4:0] r;
    case (c)
      8'h45:   r = 5'h10;
      8'h16:   r = 5'h11;
      8'h1E:   r = 5'h12;
      8'h26:   r = 5'h13;
      8'h25:   r = 5'h14;
      8'h2E:   r = 5'h15;
      8'h36:   r = 5'h16;
      8'h3D:   r = 5'h17;
      8'h3E:   r = 5'h18;
      8'h46:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  state_e                       st_q, st_d;
  logic [TmoW-1:0]              tmo_q, tmo_d;
  logic [7:0]                   last_q, last_d;
  logic [7:0]                   dir_q, dir_d;
  logic                         dir_vld_q, dir_vld_d;
  logic                         commit_q, commit_d;
  logic                         ovf_q, ovf_d;
  logic [7:0]                   out_q, out_d;
  logic                         rs_q;
  logic [FIFO_DEPTH-1:0][3:0]   fifo_q, fifo_d;
  logic [PtrW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]              cnt_q, cnt_d;

  logic       rd_edge;
  logic       make_vld;
  logic [7:0] make_code;
  logic [4:0] dig;
  logic       suppress;

  assign rd_edge = Read_Strobe & ~rs_q;

  always_comb begin
    st_d      = st_q;
    tmo_d     = tmo_q;
    last_d    = last_q;
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
    commit_d  = commit_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    fifo_d    = fifo_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    make_vld  = 1'b0;
    make_code = 8'h00;
    dig       = 5'h00;
    suppress  = 1'b0;

    // Read side effects are applied first so a same-cycle make lands in the cleared state.
    if (rd_edge) begin
      if (Port_ID == ADDR_DIR) begin
        dir_d     = 8'h00;
        dir_vld_d = 1'b0;
      end else if (Port_ID == ADDR_DAT) begin
        if (cnt_q != '0) begin
          rd_d  = rd_q + PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
        end
      end else if (Port_ID == ADDR_CMT) begin
        if (commit_q) begin
          commit_d  = 1'b0;
          dir_d     = 8'h00;
          dir_vld_d = 1'b0;
          wr_d      = '0;
          rd_d      = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end
      end
    end

    if (st_q == StIdle) begin
      tmo_d = '0;
      if (Rx_Valid) begin
        if (Rx_Data == 8'hE0) begin
          st_d = StExt;
        end else if (Rx_Data == 8'hF0) begin
          st_d = StBreak;
        end else begin
          make_vld  = 1'b1;
          make_code = Rx_Data;
        end
      end
    end else if (!Rx_Valid) begin
      if (tmo_q == TmoLast) begin
        st_d  = StIdle;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end else begin
      tmo_d = '0;
      st_d  = StIdle;
      unique case (st_q)
        StExt: begin
          if (Rx_Data == 8'hF0) begin
            st_d = StExtBreak;
          end else begin
            make_vld  = 1'b1;
            make_code = Rx_Data | 8'h80;
          end
        end
        StBreak: begin
          if (Rx_Data == last_q) last_d = 8'h00;
        end
        StExtBreak: begin
          if ((Rx_Data | 8'h80) == last_q) last_d = 8'h00;
        end
        default: ;
      endcase
    end

    if (make_vld) begin
`ifdef TYPEMATIC_FILTER_EN
      suppress = (last_q != 8'h00) && (make_code == last_q);
`else
      suppress = 1'b0;
`endif
      dig    = digit_of(make_code);
      last_d = make_code;
      if (!suppress) begin
        if (is_dir_code(make_code)) begin
          dir_d     = make_code;
          dir_vld_d = 1'b1;
        end else if (dig[4]) begin
          // Fullness is judged after any same-cycle pop.
          if (cnt_d == CntFull) begin
            ovf_d = 1'b1;
          end else begin
            fifo_d[wr_d] = dig[3:0];
            wr_d         = wr_d + PtrW'(1);
            cnt_d        = cnt_d + CntW'(1);
          end
        end else if (make_code == 8'h5A) begin
          commit_d = 1'b1;
        end
      end
    end

    // Held while the strobe is high so a read never sees its own side effect.
    if (!Read_Strobe) begin
      if (Port_ID == ADDR_DIR) begin
        out_d = dir_q;
      end else if (Port_ID == ADDR_DAT) begin
        out_d = (cnt_q == '0) ? 8'hFF : {4'h0, fifo_q[rd_q]};
      end else if (Port_ID == ADDR_CMT) begin
        out_d = {7'b0, commit_q};
      end else begin
        out_d = 8'h00;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_q      <= StIdle;
      tmo_q     <= '0;
      last_q    <= 8'h00;
      dir_q     <= 8'h00;
      dir_vld_q <= 1'b0;
      commit_q  <= 1'b0;
      ovf_q     <= 1'b0;
      out_q     <= 8'h00;
      rs_q      <= 1'b0;
      fifo_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      tmo_q     <= tmo_d;
      last_q    <= last_d;
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
      commit_q  <= commit_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      rs_q      <= Read_Strobe;
      fifo_q    <= fifo_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Keyboard_Output = out_q;
  assign Key_Pending     = dir_vld_q | (cnt_q != '0) | commit_q;
  assign Overflow        = ovf_q;

endmodule
